// File: rtl/bpi_defs.sv
// Shared BPI arbiter definitions: op codes, flash command constants, requester indices, FSM states.
package bpi_defs;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 16;
    localparam int OP_W   = 2;
    localparam int N_REQ  = 3;

    localparam logic [1:0] OP_READ    = 2'd0;
    localparam logic [1:0] OP_PROGRAM = 2'd1;
    localparam logic [1:0] OP_ERASE   = 2'd2;
    localparam logic [1:0] OP_CMD     = 2'd3;

    localparam logic [15:0] READ_ARRAY_CMD = 16'h00FF;

    localparam logic [1:0] RQ_AL     = 2'd0;
    localparam logic [1:0] RQ_USR    = 2'd1;
    localparam logic [1:0] RQ_PSTORE = 2'd2;
    localparam logic [1:0] RQ_NONE   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GRANT     = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_RISE = 3'd3,
        ST_WAIT_FALL = 3'd4,
        ST_RELEASE   = 3'd5
    } arb_state_e;

    function automatic logic [2:0] rq_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        oh = 3'b000;
        case (idx)
            RQ_AL:     oh = 3'b001;
            RQ_USR:    oh = 3'b010;
            RQ_PSTORE: oh = 3'b100;
            default:   oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/bpi_arb_pick.sv
// Winner select: requester 0 has strict priority, requesters 1 and 2 alternate starting from rr_ptr.
module bpi_arb_pick
    import bpi_defs::*;
(
    input  logic [2:0] req,
    input  logic [1:0] rr_ptr,
    output logic       valid,
    output logic [1:0] winner
);

    always_comb begin
        valid  = |req;
        winner = RQ_NONE;
        if (req[0]) begin
            winner = RQ_AL;
        end else if (rr_ptr == RQ_PSTORE) begin
            if (req[2])      winner = RQ_PSTORE;
            else if (req[1]) winner = RQ_USR;
        end else begin
            if (req[1])      winner = RQ_USR;
            else if (req[2]) winner = RQ_PSTORE;
        end
    end

endmodule

// File: rtl/bpi_op_arbiter.sv
// Three-way owner arbiter for the single BPI flash command port; grants whole bursts, one op in flight.
// Optional BUSY watchdog enabled by defining BPI_ARB_WDOG_EN.
module bpi_op_arbiter
    import bpi_defs::*;
#(
    parameter logic [3:0]  BUSY_WAIT  = 4'd8,
    parameter logic [15:0] IDLE_MAX   = 16'd1024,
    parameter logic [23:0] WDOG_LIMIT = 24'd5_000_000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [2:0]  REQ,
    input  logic [2:0]  REQ_EXEC,
    input  logic [68:0] REQ_ADDR,
    input  logic [47:0] REQ_DATA,
    input  logic [5:0]  REQ_OP,
    output logic [2:0]  GNT,
    output logic [2:0]  OP_DONE,
    output logic [22:0] BPI_ADDR,
    output logic [15:0] BPI_CMD_DATA,
    output logic [1:0]  BPI_OP,
    output logic        BPI_EXECUTE,
    input  logic        BPI_BUSY,
    output logic [1:0]  ARB_OWNER,
    output logic        ARB_ABORT,
    output logic [2:0]  ARB_STATUS,
    output logic [2:0]  DBG_STATE
);

    arb_state_e  state_q, state_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [2:0]  op_done_q, op_done_d;
    logic        exec_q, exec_d;
    logic [22:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic [3:0]  rise_cnt_q, rise_cnt_d;
    logic [2:0]  status_q, status_d;
`ifdef BPI_ARB_WDOG_EN
    logic [23:0] wdog_cnt_q, wdog_cnt_d;
    logic        abort_q, abort_d;
`endif

    logic        pick_valid;
    logic [1:0]  pick_winner;
    logic [2:0]  own_mask;
    logic [2:0]  accept_mask;
    logic        owner_req;
    logic        owner_exec;
    logic        ignored_exec;
    logic [22:0] sel_addr;
    logic [15:0] sel_data;
    logic [1:0]  sel_op;

    bpi_arb_pick u_pick (
        .req    (REQ),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_comb begin
        sel_addr = REQ_ADDR[22:0];
        sel_data = REQ_DATA[15:0];
        sel_op   = REQ_OP[1:0];
        case (owner_q)
            RQ_USR: begin
                sel_addr = REQ_ADDR[45:23];
                sel_data = REQ_DATA[31:16];
                sel_op   = REQ_OP[3:2];
            end
            RQ_PSTORE: begin
                sel_addr = REQ_ADDR[68:46];
                sel_data = REQ_DATA[47:32];
                sel_op   = REQ_OP[5:4];
            end
            default: ;
        endcase
    end

    // Only the owner's strobe in GRANT is accepted; every other strobe bit is flagged.
    assign own_mask     = rq_onehot(owner_q);
    assign accept_mask  = (state_q == ST_GRANT) ? own_mask : 3'b000;
    assign owner_req    = |(REQ & own_mask);
    assign owner_exec   = |(REQ_EXEC & accept_mask);
    assign ignored_exec = |(REQ_EXEC & ~accept_mask);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        op_done_d  = 3'b000;
        exec_d     = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        op_d       = op_q;
        idle_cnt_d = idle_cnt_q;
        rise_cnt_d = rise_cnt_q;
        status_d   = status_q | {2'b00, ignored_exec};
`ifdef BPI_ARB_WDOG_EN
        wdog_cnt_d = wdog_cnt_q;
        abort_d    = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d    = ST_GRANT;
                    gnt_d      = rq_onehot(pick_winner);
                    owner_d    = pick_winner;
                    idle_cnt_d = 16'd0;
                    if (pick_winner == RQ_USR)    rr_ptr_d = RQ_PSTORE;
                    if (pick_winner == RQ_PSTORE) rr_ptr_d = RQ_USR;
                end
            end
            ST_GRANT: begin
                // An accepted strobe beats a simultaneous REQ drop; release follows that op.
                if (owner_exec) begin
                    state_d    = ST_ISSUE;
                    exec_d     = 1'b1;
                    addr_d     = sel_addr;
                    data_d     = sel_data;
                    op_d       = sel_op;
                    idle_cnt_d = 16'd0;
                end else if (!owner_req) begin
                    state_d = ST_RELEASE;
                    gnt_d   = 3'b000;
                    owner_d = RQ_NONE;
                end else if (idle_cnt_q == IDLE_MAX - 16'd1) begin
                    state_d     = ST_RELEASE;
                    gnt_d       = 3'b000;
                    owner_d     = RQ_NONE;
                    status_d[1] = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                end
            end
            ST_ISSUE: begin
                state_d    = ST_WAIT_RISE;
                rise_cnt_d = 4'd0;
            end
            ST_WAIT_RISE: begin
                if (BPI_BUSY) begin
                    state_d = ST_WAIT_FALL;
`ifdef BPI_ARB_WDOG_EN
                    wdog_cnt_d = 24'd0;
`endif
                end else if (rise_cnt_q == BUSY_WAIT - 4'd1) begin
                    op_done_d = own_mask;
                    if (owner_req) begin
                        state_d = ST_GRANT;
                    end else begin
                        state_d = ST_RELEASE;
                        gnt_d   = 3'b000;
                        owner_d = RQ_NONE;
                    end
                end else begin
                    rise_cnt_d = rise_cnt_q + 4'd1;
                end
            end
            ST_WAIT_FALL: begin
                if (!BPI_BUSY) begin
                    op_done_d = own_mask;
                    if (owner_req) begin
                        state_d = ST_GRANT;
                    end else begin
                        state_d = ST_RELEASE;
                        gnt_d   = 3'b000;
                        owner_d = RQ_NONE;
                    end
                end
`ifdef BPI_ARB_WDOG_EN
                else if (wdog_cnt_q == WDOG_LIMIT - 24'd1) begin
                    abort_d     = 1'b1;
                    status_d[2] = 1'b1;
                    state_d     = ST_RELEASE;
                    gnt_d       = 3'b000;
                    owner_d     = RQ_NONE;
                end else begin
                    wdog_cnt_d = wdog_cnt_q + 24'd1;
                end
`endif
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 3'b000;
                owner_d = RQ_NONE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 3'b000;
            owner_q    <= RQ_NONE;
            rr_ptr_q   <= RQ_USR;
            op_done_q  <= 3'b000;
            exec_q     <= 1'b0;
            addr_q     <= 23'd0;
            data_q     <= 16'd0;
            op_q       <= 2'd0;
            idle_cnt_q <= 16'd0;
            rise_cnt_q <= 4'd0;
            status_q   <= 3'b000;
`ifdef BPI_ARB_WDOG_EN
            wdog_cnt_q <= 24'd0;
            abort_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            op_done_q  <= op_done_d;
            exec_q     <= exec_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            op_q       <= op_d;
            idle_cnt_q <= idle_cnt_d;
            rise_cnt_q <= rise_cnt_d;
            status_q   <= status_d;
`ifdef BPI_ARB_WDOG_EN
            wdog_cnt_q <= wdog_cnt_d;
            abort_q    <= abort_d;
`endif
        end
    end

    assign GNT          = gnt_q;
    assign OP_DONE      = op_done_q;
    assign BPI_ADDR     = addr_q;
    assign BPI_CMD_DATA = data_q;
    assign BPI_OP       = op_q;
    assign BPI_EXECUTE  = exec_q;
    assign ARB_OWNER    = owner_q;
    assign ARB_STATUS   = status_q;
    assign DBG_STATE    = state_q;
`ifdef BPI_ARB_WDOG_EN
    assign ARB_ABORT    = abort_q;
`else
    assign ARB_ABORT    = 1'b0;
`endif

endmodule

// File: tb/tb_bpi_op_arbiter.sv
// Self-checking bench for bpi_op_arbiter: directed bursts plus randomized rounds against a cycle-level model.
module tb_bpi_op_arbiter;
    import bpi_defs::*;

    localparam int BUSY_WAIT_CYC = 8;
    localparam int IDLE_CYC      = 1024;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [2:0]  REQ;
    logic [2:0]  REQ_EXEC;
    logic [68:0] REQ_ADDR;
    logic [47:0] REQ_DATA;
    logic [5:0]  REQ_OP;
    logic [2:0]  GNT;
    logic [2:0]  OP_DONE;
    logic [22:0] BPI_ADDR;
    logic [15:0] BPI_CMD_DATA;
    logic [1:0]  BPI_OP;
    logic        BPI_EXECUTE;
    logic        BPI_BUSY;
    logic [1:0]  ARB_OWNER;
    logic        ARB_ABORT;
    logic [2:0]  ARB_STATUS;
    logic [2:0]  DBG_STATE;

    int          checks = 0;
    int          errors = 0;
    int          rr;
    int          exec_seen;
    int          done_seen;
    logic [2:0]  exp_status;
    logic [22:0] exp_q[$];

    bpi_op_arbiter #(.WDOG_LIMIT(24'd100)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .REQ          (REQ),
        .REQ_EXEC     (REQ_EXEC),
        .REQ_ADDR     (REQ_ADDR),
        .REQ_DATA     (REQ_DATA),
        .REQ_OP       (REQ_OP),
        .GNT          (GNT),
        .OP_DONE      (OP_DONE),
        .BPI_ADDR     (BPI_ADDR),
        .BPI_CMD_DATA (BPI_CMD_DATA),
        .BPI_OP       (BPI_OP),
        .BPI_EXECUTE  (BPI_EXECUTE),
        .BPI_BUSY     (BPI_BUSY),
        .ARB_OWNER    (ARB_OWNER),
        .ARB_ABORT    (ARB_ABORT),
        .ARB_STATUS   (ARB_STATUS),
        .DBG_STATE    (DBG_STATE)
    );

    // Clock and global time bound
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "simulation time bound exceeded");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    function automatic logic [2:0] oh(input int w);
        logic [2:0] r;
        r = 3'b000;
        if (w >= 0 && w < 3) r[w] = 1'b1;
        return r;
    endfunction

    // Reference arbitration: 0 always wins, else the round-robin favourite, else the other one.
    function automatic int model_pick(input logic [2:0] r);
        int w;
        w = 3;
        if (r[0])           w = 0;
        else if (r[rr])     w = rr;
        else if (r[3 - rr]) w = 3 - rr;
        return w;
    endfunction

    task automatic model_grant(input int w);
        if (w == 1 || w == 2) rr = 3 - w;
    endtask

    task automatic grant_from_idle(output int w);
        tick();
        w = model_pick(REQ);
        check_eq("grant_gnt", 32'(GNT), 32'(oh(w)));
        check_eq("grant_owner", 32'(ARB_OWNER), 32'(w));
        model_grant(w);
    endtask

    // Called on the negedge where RELEASE is visible: one dead cycle, one IDLE cycle, then the grant.
    task automatic after_release(input logic [2:0] newbits, output int w);
        REQ = REQ | newbits;
        tick();
        check_eq("dead_gnt", 32'(GNT), 32'd0);
        check_eq("dead_owner", 32'(ARB_OWNER), 32'd3);
        tick();
        w = model_pick(REQ);
        check_eq("regrant_gnt", 32'(GNT), 32'(oh(w)));
        check_eq("regrant_owner", 32'(ARB_OWNER), 32'(w));
        model_grant(w);
    endtask

    // Driver for one op from owner w. BUSY rises d cycles after EXECUTE is seen and stays l cycles.
    task automatic run_op(input int w, input logic [22:0] a, input logic [15:0] dt, input logic [1:0] op,
                          input int d, input int l, input bit nobusy, input int drop_n, input bit poke,
                          output bit dropped);
        int done_n;
        dropped = 1'b0;
        REQ_EXEC = oh(w);
        REQ_ADDR[w*23 +: 23] = a;
        REQ_DATA[w*16 +: 16] = dt;
        REQ_OP[w*2 +: 2] = op;
        exp_q.push_back(a);
        if (drop_n == 0) begin
            REQ[w] = 1'b0;
            dropped = 1'b1;
        end
        tick();
        REQ_EXEC = 3'b000;
        check_eq("exec_hi", 32'(BPI_EXECUTE), 32'd1);
        if (BPI_EXECUTE) exec_seen++;
        check_eq("bpi_addr", 32'(BPI_ADDR), 32'(exp_q.pop_front()));
        check_eq("bpi_data", 32'(BPI_CMD_DATA), 32'(dt));
        check_eq("bpi_op", 32'(BPI_OP), 32'(op));
        check_eq("op_owner", 32'(ARB_OWNER), 32'(w));
        done_n = nobusy ? BUSY_WAIT_CYC + 1 : d + l + 1;
        for (int n = 0; n <= done_n; n++) begin
            if (n > 0) begin
                check_eq("exec_lo", 32'(BPI_EXECUTE), 32'd0);
                check_eq("op_done", 32'(OP_DONE), 32'((n == done_n) ? oh(w) : 3'b000));
                if (OP_DONE != 3'b000) done_seen++;
            end
            BPI_BUSY = !nobusy && (n >= d) && (n < d + l);
            if (n == drop_n && n > 0) begin
                REQ[w] = 1'b0;
                dropped = 1'b1;
            end
            if (poke && n == 2) begin
                REQ_EXEC = oh(w);
                exp_status[0] = 1'b1;
            end else if (n == 3) begin
                REQ_EXEC = 3'b000;
            end
            if (n < done_n) tick();
        end
        check_eq("post_gnt", 32'(GNT), 32'(dropped ? 3'b000 : oh(w)));
        check_eq("post_owner", 32'(ARB_OWNER), 32'(dropped ? 3 : w));
    endtask

    initial begin
        int  w;
        int  cnt;
        int  nops;
        int  choice;
        int  other;
        bit  dropped;

        RST_N      = 1'b0;
        REQ        = 3'b000;
        REQ_EXEC   = 3'b000;
        REQ_ADDR   = '0;
        REQ_DATA   = '0;
        REQ_OP     = '0;
        BPI_BUSY   = 1'b0;
        exp_status = 3'b000;
        rr         = 1;
        exec_seen  = 0;
        done_seen  = 0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        // Reset values
        check_eq("rst_gnt", 32'(GNT), 32'd0);
        check_eq("rst_done", 32'(OP_DONE), 32'd0);
        check_eq("rst_addr", 32'(BPI_ADDR), 32'd0);
        check_eq("rst_data", 32'(BPI_CMD_DATA), 32'd0);
        check_eq("rst_op", 32'(BPI_OP), 32'd0);
        check_eq("rst_exec", 32'(BPI_EXECUTE), 32'd0);
        check_eq("rst_owner", 32'(ARB_OWNER), 32'd3);
        check_eq("rst_abort", 32'(ARB_ABORT), 32'd0);
        check_eq("rst_status", 32'(ARB_STATUS), 32'd0);
        check_eq("rst_state", 32'(DBG_STATE), 32'(ST_IDLE));

        // Round-robin between 1 and 2
        REQ = 3'b110;
        grant_from_idle(w);
        check_eq("t1_first", 32'(GNT), 32'(3'b010));
        REQ = 3'b000;
        tick();
        check_eq("t1_rel", 32'(GNT), 32'd0);
        REQ = 3'b110;
        after_release(3'b000, w);
        check_eq("t1_second", 32'(GNT), 32'(3'b100));
        REQ = 3'b000;
        tick();
        check_eq("t1_rel2", 32'(GNT), 32'd0);

        // 34-word auto-load burst with requester 0 holding priority
        REQ = 3'b111;
        after_release(3'b000, w);
        exec_seen = 0;
        done_seen = 0;
        for (int i = 0; i < 34; i++) begin
            run_op(0, 23'h7FC000 + 23'(i), READ_ARRAY_CMD, OP_READ, 1, 5, 1'b0, -1, 1'b0, dropped);
        end
        check_eq("t2_exec_cnt", 32'(exec_seen), 32'd34);
        check_eq("t2_done_cnt", 32'(done_seen), 32'd34);
        REQ[0] = 1'b0;
        tick();
        check_eq("t2_rel", 32'(GNT), 32'd0);
        after_release(3'b000, w);
        check_eq("t2_next", 32'(GNT), 32'(3'b010));

        // BUSY never rises: completion after the rise window
        run_op(1, 23'h000123, 16'h1234, OP_PROGRAM, 0, 0, 1'b1, -1, 1'b0, dropped);

        // Non-owner strobe ignored, then owner drops REQ mid-op
        REQ_EXEC = 3'b100;
        tick();
        REQ_EXEC = 3'b000;
        exp_status[0] = 1'b1;
        check_eq("t4_no_exec", 32'(BPI_EXECUTE), 32'd0);
        check_eq("t4_status", 32'(ARB_STATUS), 32'(3'b001));
        run_op(1, 23'h055AA5, 16'h00E8, OP_ERASE, 1, 4, 1'b0, 1, 1'b0, dropped);
        after_release(3'b000, w);

        // Randomized rounds
        for (int r = 0; r < 20; r++) begin
            nops = $urandom_range(1, 3);
            for (int i = 0; i < nops; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    other = (w + 1 + $urandom_range(0, 1)) % 3;
                    REQ_EXEC = oh(other);
                    tick();
                    REQ_EXEC = 3'b000;
                    exp_status[0] = 1'b1;
                    check_eq("rnd_ign_exec", 32'(BPI_EXECUTE), 32'd0);
                    check_eq("rnd_ign_gnt", 32'(GNT), 32'(oh(w)));
                end
                choice = (i == nops - 1) ? $urandom_range(0, 2) : 3;
                run_op(w, 23'($urandom), 16'($urandom), 2'($urandom_range(0, 3)),
                       $urandom_range(1, 4), $urandom_range(1, 6), ($urandom_range(0, 5) == 0),
                       (choice == 1) ? 0 : ((choice == 2) ? 1 : -1), $urandom_range(0, 1) == 1, dropped);
            end
            if (!dropped) begin
                REQ[w] = 1'b0;
                tick();
                check_eq("rnd_rel", 32'(GNT), 32'd0);
            end
            check_eq("rnd_status", 32'(ARB_STATUS), 32'(exp_status));
            after_release(3'($urandom_range(0, 7)), w);
            if (w == 3) begin
                REQ = 3'($urandom_range(1, 7));
                grant_from_idle(w);
            end
        end

        // Idle owner is forced off after IDLE_CYC granted cycles
        cnt = 0;
        while (GNT != 3'b000 && cnt < 2000) begin
            cnt++;
            tick();
        end
        check_eq("t5_idle_len", 32'(cnt), 32'(IDLE_CYC));
        exp_status[1] = 1'b1;
        check_eq("t5_status", 32'(ARB_STATUS), 32'(exp_status));
        REQ = 3'b000;
        after_release(3'b001, w);

`ifdef BPI_ARB_WDOG_EN
        // BUSY stuck high: abort 100 cycles into WAIT_FALL, no completion
        REQ_EXEC = 3'b001;
        tick();
        REQ_EXEC = 3'b000;
        check_eq("t6_exec", 32'(BPI_EXECUTE), 32'd1);
        for (int n = 1; n <= 103; n++) begin
            if (n == 1) BPI_BUSY = 1'b1;
            tick();
            check_eq("t6_abort", 32'(ARB_ABORT), 32'((n + 1 == 102) ? 1 : 0));
            check_eq("t6_no_done", 32'(OP_DONE), 32'd0);
            if (n + 1 == 102) begin
                exp_status[2] = 1'b1;
                check_eq("t6_status", 32'(ARB_STATUS), 32'(exp_status));
                check_eq("t6_gnt", 32'(GNT), 32'd0);
                REQ = 3'b000;
            end
        end
        BPI_BUSY = 1'b0;
        tick();
        after_release(3'b001, w);
`endif

        // Asynchronous reset with an op in flight
        REQ_EXEC = 3'b001;
        REQ_ADDR[22:0] = 23'h12345;
        tick();
        REQ_EXEC = 3'b000;
        check_eq("rm_exec", 32'(BPI_EXECUTE), 32'd1);
        BPI_BUSY = 1'b1;
        tick();
        tick();
        #2 RST_N = 1'b0;
        #1;
        check_eq("arst_gnt", 32'(GNT), 32'd0);
        check_eq("arst_owner", 32'(ARB_OWNER), 32'd3);
        check_eq("arst_addr", 32'(BPI_ADDR), 32'd0);
        check_eq("arst_data", 32'(BPI_CMD_DATA), 32'd0);
        check_eq("arst_op", 32'(BPI_OP), 32'd0);
        check_eq("arst_status", 32'(ARB_STATUS), 32'd0);
        check_eq("arst_abort", 32'(ARB_ABORT), 32'd0);
        check_eq("arst_state", 32'(DBG_STATE), 32'(ST_IDLE));
        BPI_BUSY = 1'b0;
        REQ = 3'b000;
        @(negedge CLK);
        RST_N = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            check_eq("arst_no_done", 32'(OP_DONE), 32'd0);
            check_eq("arst_idle_gnt", 32'(GNT), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
